// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the two-port on-chip memory arbiter: port encoding,
// weight limits and the weight clamp used by the arbiter.
package onchip_mem_pkg;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_e;

  localparam int WEIGHT_MIN = 1;
  localparam int WEIGHT_MAX = 15;
  localparam int RUN_W      = 4;

  // Out-of-range weights are pulled into range so the run counter can never overflow.
  function automatic logic [RUN_W-1:0] clamp_weight(input int w);
    logic [RUN_W-1:0] r;
    if (w < WEIGHT_MIN) begin
      r = RUN_W'(WEIGHT_MIN);
    end else if (w > WEIGHT_MAX) begin
      r = RUN_W'(WEIGHT_MAX);
    end else begin
      r = RUN_W'(w);
    end
    return r;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Bundle of both requester ports and the memory-side bus; the arbiter uses the
// slave view, requesters plus the memory macro sit on the master view.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   m0_address;
  logic                m0_read;
  logic                m0_write;
  logic [DATA_W-1:0]   m0_writedata;
  logic [DATA_W/8-1:0] m0_byteenable;
  logic                m0_debugaccess;
  logic                m0_waitrequest;
  logic [DATA_W-1:0]   m0_readdata;
  logic                m0_readdatavalid;

  logic [ADDR_W-1:0]   m1_address;
  logic                m1_read;
  logic                m1_write;
  logic [DATA_W-1:0]   m1_writedata;
  logic [DATA_W/8-1:0] m1_byteenable;
  logic                m1_debugaccess;
  logic                m1_waitrequest;
  logic [DATA_W-1:0]   m1_readdata;
  logic                m1_readdatavalid;

  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_debugaccess;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  modport slave (
    input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable, m0_debugaccess,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_debugaccess,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    output mem_debugaccess, mem_clken,
    input  mem_readdata
  );

  modport master (
    output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable, m0_debugaccess,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_debugaccess,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    input  mem_debugaccess, mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/rr_weighted_arbiter.sv
// Two-way weighted round-robin: m0 may take up to WEIGHT0 consecutive grants
// while m1 waits, then m1 gets one.
module rr_weighted_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int WEIGHT0 = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam logic [RUN_W-1:0] WEIGHT_L = clamp_weight(WEIGHT0);

  port_e            last_grant_r;
  logic [RUN_W-1:0] run_cnt_r;

  // Grant decision from current requests and registered fairness state
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if ((last_grant_r == PORT_M1) || (run_cnt_r < WEIGHT_L)) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

  // Last-grant pointer and m0 run counter; the run only grows while m1 is actually waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= PORT_M1;
      run_cnt_r    <= {RUN_W{1'b0}};
    end else if (gnt[1]) begin
      last_grant_r <= PORT_M1;
      run_cnt_r    <= {RUN_W{1'b0}};
    end else if (gnt[0]) begin
      last_grant_r <= PORT_M0;
      if (req[1]) begin
        run_cnt_r <= run_cnt_r + RUN_W'(1);
      end else begin
        run_cnt_r <= run_cnt_r;
      end
    end else begin
      last_grant_r <= last_grant_r;
      run_cnt_r    <= run_cnt_r;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port on-chip memory between two requesters; the granted
// port drives the memory directly and read data returns one cycle later.
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int WEIGHT0 = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  onchip_mem_arbiter_if.slave  bus
);

  logic                m0_req_s;
  logic                m1_req_s;
  logic [1:0]          req_s;
  logic [1:0]          gnt_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [DATA_W/8-1:0] be_s;
  logic [DATA_W-1:0]   wdata_s;
  logic                write_s;
  logic                dbg_s;
  logic                cs_s;
  logic                rd_pend_r;
  port_e               rd_owner_r;

  assign m0_req_s = bus.m0_read | bus.m0_write;
  assign m1_req_s = bus.m1_read | bus.m1_write;
  // Masking requests during reset keeps the memory idle and every requester stalled
  assign req_s    = reset ? 2'b00 : {m1_req_s, m0_req_s};

  rr_weighted_arbiter #(
    .WEIGHT0 (WEIGHT0)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_s),
    .gnt   (gnt_s)
  );

  // Memory-side mux: the granted port steers the memory in its grant cycle
  always_comb begin
    addr_s  = {ADDR_W{1'b0}};
    be_s    = {(DATA_W/8){1'b0}};
    wdata_s = {DATA_W{1'b0}};
    write_s = 1'b0;
    dbg_s   = 1'b0;
    case (gnt_s)
      2'b01: begin
        addr_s  = bus.m0_address;
        be_s    = bus.m0_byteenable;
        wdata_s = bus.m0_writedata;
        write_s = bus.m0_write;
        dbg_s   = bus.m0_debugaccess;
      end
      2'b10: begin
        addr_s  = bus.m1_address;
        be_s    = bus.m1_byteenable;
        wdata_s = bus.m1_writedata;
        write_s = bus.m1_write;
        dbg_s   = bus.m1_debugaccess;
      end
      default: begin
        addr_s  = {ADDR_W{1'b0}};
        be_s    = {(DATA_W/8){1'b0}};
        wdata_s = {DATA_W{1'b0}};
        write_s = 1'b0;
        dbg_s   = 1'b0;
      end
    endcase
  end

  assign cs_s                = gnt_s[0] | gnt_s[1];
  assign bus.mem_address     = addr_s;
  assign bus.mem_byteenable  = be_s;
  assign bus.mem_writedata   = wdata_s;
  assign bus.mem_write       = write_s;
  assign bus.mem_debugaccess = dbg_s;
  assign bus.mem_chipselect  = cs_s;
  assign bus.mem_clken       = 1'b1;

  assign bus.m0_waitrequest  = m0_req_s & ~gnt_s[0];
  assign bus.m1_waitrequest  = m1_req_s & ~gnt_s[1];

  // Read-return tracker: remembers which port owns the data arriving next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= PORT_M0;
    end else if (cs_s && !write_s) begin
      rd_pend_r  <= 1'b1;
      rd_owner_r <= gnt_s[1] ? PORT_M1 : PORT_M0;
    end else begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= rd_owner_r;
    end
  end

  // Gating with reset drops a read whose data would land in the first reset cycle
  assign bus.m0_readdatavalid = rd_pend_r & (rd_owner_r == PORT_M0) & ~reset;
  assign bus.m1_readdatavalid = rd_pend_r & (rd_owner_r == PORT_M1) & ~reset;
  assign bus.m0_readdata      = bus.mem_readdata;
  assign bus.m1_readdata      = bus.mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench: instance A (WEIGHT0=1) with a byte-enabled memory model,
// instance B (WEIGHT0=3) whose memory returns the read address as data.
module tb_onchip_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WEIGHT0(1)) dut_a (
    .clk (clk), .reset (reset), .bus (bus_a)
  );
  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WEIGHT0(3)) dut_b (
    .clk (clk), .reset (reset), .bus (bus_b)
  );

  logic [31:0] mem_a [0:1023];

  always @(posedge clk) begin
    if (bus_a.mem_chipselect && bus_a.mem_clken) begin
      if (bus_a.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus_a.mem_byteenable[b])
            mem_a[bus_a.mem_address][8*b +: 8] <= bus_a.mem_writedata[8*b +: 8];
      end else begin
        bus_a.mem_readdata <= mem_a[bus_a.mem_address];
      end
    end
  end

  always @(posedge clk) begin
    if (bus_b.mem_chipselect && !bus_b.mem_write)
      bus_b.mem_readdata <= {22'd0, bus_b.mem_address};
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a0(input logic rd, input logic wr, input logic [9:0] ad,
                          input logic [31:0] wd, input logic [3:0] be, input logic dbg);
    bus_a.m0_read = rd; bus_a.m0_write = wr; bus_a.m0_address = ad;
    bus_a.m0_writedata = wd; bus_a.m0_byteenable = be; bus_a.m0_debugaccess = dbg;
  endtask

  task automatic drive_a1(input logic rd, input logic wr, input logic [9:0] ad,
                          input logic [31:0] wd, input logic [3:0] be, input logic dbg);
    bus_a.m1_read = rd; bus_a.m1_write = wr; bus_a.m1_address = ad;
    bus_a.m1_writedata = wd; bus_a.m1_byteenable = be; bus_a.m1_debugaccess = dbg;
  endtask

  task automatic drive_b(input logic rd0, input logic [9:0] ad0, input logic rd1, input logic [9:0] ad1);
    bus_b.m0_read = rd0; bus_b.m0_write = 1'b0; bus_b.m0_address = ad0;
    bus_b.m0_writedata = 32'd0; bus_b.m0_byteenable = 4'hF; bus_b.m0_debugaccess = 1'b0;
    bus_b.m1_read = rd1; bus_b.m1_write = 1'b0; bus_b.m1_address = ad1;
    bus_b.m1_writedata = 32'd0; bus_b.m1_byteenable = 4'hF; bus_b.m1_debugaccess = 1'b0;
  endtask

  task automatic idle_a();
    drive_a0(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
    drive_a1(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wait_hi;
    logic grant_m1;
    logic prev_m1;

    for (int i = 0; i < 1024; i++) mem_a[i] = 32'h1000_0000 + i;
    mem_a[10'h005] = 32'hA5A5_0005;
    mem_a[10'h3FF] = 32'h0BAD_F00D;
    mem_a[10'h010] = 32'hFFFF_FFFF;
    idle_a();
    drive_b(1'b0, 10'd0, 1'b0, 10'd0);

    // Reset with m0 requesting: nothing granted, m0 stalled
    drive_a0(1'b1, 1'b0, 10'h005, 32'd0, 4'hF, 1'b0);
    @(negedge clk);
    check_eq("rst_cs", bus_a.mem_chipselect, 1'b0);
    check_eq("rst_wr", bus_a.mem_write, 1'b0);
    check_eq("rst_m0_wait", bus_a.m0_waitrequest, 1'b1);
    check_eq("rst_m0_rdv", bus_a.m0_readdatavalid, 1'b0);
    check_eq("rst_m1_rdv", bus_a.m1_readdatavalid, 1'b0);
    step();
    reset = 1'b0;

    // Single m0 read of word 5
    @(negedge clk);
    check_eq("rd5_wait", bus_a.m0_waitrequest, 1'b0);
    check_eq("rd5_cs", bus_a.mem_chipselect, 1'b1);
    check_eq("rd5_addr", bus_a.mem_address, 10'h005);
    check_eq("rd5_wr", bus_a.mem_write, 1'b0);
    step();
    idle_a();
    @(negedge clk);
    check_eq("rd5_rdv", bus_a.m0_readdatavalid, 1'b1);
    check_eq("rd5_data", bus_a.m0_readdata, 32'hA5A5_0005);
    check_eq("rd5_m1_rdv", bus_a.m1_readdatavalid, 1'b0);
    check_eq("rd5_idle_cs", bus_a.mem_chipselect, 1'b0);
    step();

    // Both reading continuously, WEIGHT0=1: m0,m1,m0,m1
    drive_a0(1'b1, 1'b0, 10'h001, 32'd0, 4'hF, 1'b0);
    drive_a1(1'b1, 1'b0, 10'h002, 32'd0, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      grant_m1 = (i % 2 == 1);
      check_eq($sformatf("alt%0d_m0_wait", i), bus_a.m0_waitrequest, grant_m1);
      check_eq($sformatf("alt%0d_m1_wait", i), bus_a.m1_waitrequest, !grant_m1);
      check_eq($sformatf("alt%0d_m0_rdv", i), bus_a.m0_readdatavalid, (i % 2 == 1));
      check_eq($sformatf("alt%0d_m1_rdv", i), bus_a.m1_readdatavalid, (i > 0) && (i % 2 == 0));
      if (i == 1) check_eq("alt1_m0_data", bus_a.m0_readdata, 32'h1000_0001);
      if (i == 2) check_eq("alt2_m1_data", bus_a.m1_readdata, 32'h1000_0002);
      step();
    end
    idle_a();
    @(negedge clk);
    check_eq("alt_end_m1_rdv", bus_a.m1_readdatavalid, 1'b1);
    check_eq("alt_end_m0_rdv", bus_a.m0_readdatavalid, 1'b0);
    check_eq("alt_end_data", bus_a.m1_readdata, 32'h1000_0002);
    step();

    // m1 debug write vs m0 read of 0x3FF: m0 first, sees old data
    drive_a0(1'b1, 1'b0, 10'h3FF, 32'd0, 4'hF, 1'b0);
    drive_a1(1'b0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 4'hF, 1'b1);
    @(negedge clk);
    check_eq("wr3ff_m0_wait", bus_a.m0_waitrequest, 1'b0);
    check_eq("wr3ff_m1_wait", bus_a.m1_waitrequest, 1'b1);
    check_eq("wr3ff_c0_wr", bus_a.mem_write, 1'b0);
    check_eq("wr3ff_c0_dbg", bus_a.mem_debugaccess, 1'b0);
    step();
    drive_a0(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
    @(negedge clk);
    check_eq("wr3ff_m1_wait2", bus_a.m1_waitrequest, 1'b0);
    check_eq("wr3ff_c1_wr", bus_a.mem_write, 1'b1);
    check_eq("wr3ff_c1_dbg", bus_a.mem_debugaccess, 1'b1);
    check_eq("wr3ff_c1_wdata", bus_a.mem_writedata, 32'hDEAD_BEEF);
    check_eq("wr3ff_old_rdv", bus_a.m0_readdatavalid, 1'b1);
    check_eq("wr3ff_old_data", bus_a.m0_readdata, 32'h0BAD_F00D);
    step();
    idle_a();
    drive_a0(1'b1, 1'b0, 10'h3FF, 32'd0, 4'hF, 1'b0);
    @(negedge clk);
    check_eq("wr3ff_no_wr_rdv", bus_a.m1_readdatavalid, 1'b0);
    step();
    idle_a();
    @(negedge clk);
    check_eq("wr3ff_new_rdv", bus_a.m0_readdatavalid, 1'b1);
    check_eq("wr3ff_new_data", bus_a.m0_readdata, 32'hDEAD_BEEF);
    step();

    // Partial write: low two bytes of 0x010
    drive_a0(1'b0, 1'b1, 10'h010, 32'h1234_5678, 4'h3, 1'b0);
    @(negedge clk);
    check_eq("be3_cs", bus_a.mem_chipselect, 1'b1);
    check_eq("be3_be", bus_a.mem_byteenable, 4'h3);
    step();
    drive_a0(1'b1, 1'b0, 10'h010, 32'd0, 4'hF, 1'b0);
    @(negedge clk);
    check_eq("be3_no_rdv", bus_a.m0_readdatavalid, 1'b0);
    step();
    idle_a();
    @(negedge clk);
    check_eq("be3_rdv", bus_a.m0_readdatavalid, 1'b1);
    check_eq("be3_data", bus_a.m0_readdata, 32'hFFFF_5678);
    step();

    // Reset the cycle after an m1 read grant: the read is dropped
    drive_a1(1'b1, 1'b0, 10'h002, 32'd0, 4'hF, 1'b0);
    @(negedge clk);
    check_eq("rr_m1_wait", bus_a.m1_waitrequest, 1'b0);
    step();
    reset = 1'b1;
    drive_a0(1'b1, 1'b0, 10'h001, 32'd0, 4'hF, 1'b0);
    @(negedge clk);
    check_eq("rr_m1_rdv", bus_a.m1_readdatavalid, 1'b0);
    check_eq("rr_cs", bus_a.mem_chipselect, 1'b0);
    check_eq("rr_m0_wait", bus_a.m0_waitrequest, 1'b1);
    check_eq("rr_m1_wait2", bus_a.m1_waitrequest, 1'b1);
    step();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rr_post_m0_wait", bus_a.m0_waitrequest, 1'b0);
    check_eq("rr_post_m1_wait", bus_a.m1_waitrequest, 1'b1);
    check_eq("rr_post_m1_rdv", bus_a.m1_readdatavalid, 1'b0);
    step();
    idle_a();

    // WEIGHT0=3 on instance B: m0,m0,m0,m1 repeating
    drive_b(1'b1, 10'h007, 1'b1, 10'h009);
    wait_hi = 0;
    prev_m1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      grant_m1 = (i % 4 == 3);
      if (bus_b.m1_waitrequest) wait_hi++;
      check_eq($sformatf("w3_%0d_m1_wait", i), bus_b.m1_waitrequest, !grant_m1);
      check_eq($sformatf("w3_%0d_m0_wait", i), bus_b.m0_waitrequest, grant_m1);
      check_eq($sformatf("w3_%0d_m0_rdv", i), bus_b.m0_readdatavalid, (i > 0) && !prev_m1);
      check_eq($sformatf("w3_%0d_m1_rdv", i), bus_b.m1_readdatavalid, prev_m1);
      if (i == 2) check_eq("w3_m0_data", bus_b.m0_readdata, 32'h0000_0007);
      if (i == 4) check_eq("w3_m1_data", bus_b.m1_readdata, 32'h0000_0009);
      prev_m1 = grant_m1;
      step();
    end
    check_eq("w3_m1_wait_count", wait_hi, 6);
    drive_b(1'b0, 10'd0, 1'b0, 10'd0);
    @(negedge clk);
    check_eq("w3_end_m1_rdv", bus_b.m1_readdatavalid, 1'b1);
    check_eq("w3_end_m0_rdv", bus_b.m0_readdatavalid, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word address width of the shared on-chip memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter WEIGHT0, default 1, range 1..15, maximum consecutive grants to port 0 while port 1 waits.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have, for each requester p in {m0, m1}: p_address input ADDR_W; p_read input 1; p_write input 1; p_writedata input DATA_W; p_byteenable input DATA_W/8; p_debugaccess input 1.
REQ-007 SHALL have, for each requester p: p_waitrequest output 1; p_readdata output DATA_W; p_readdatavalid output 1.
REQ-008 SHALL have memory-side outputs mem_address ADDR_W, mem_byteenable DATA_W/8, mem_chipselect 1, mem_write 1, mem_writedata DATA_W, mem_debugaccess 1, mem_clken 1.
REQ-009 SHALL have memory-side input mem_readdata DATA_W, valid one cycle after mem_chipselect with mem_write low.

Function
REQ-010 SHALL treat a port as requesting when p_read or p_write is high; p_read and p_write both high is illegal and SHALL be served as a write.
REQ-011 SHALL grant at most one port per cycle; the granted port's address/data/byteenable/debugaccess SHALL drive the mem_* outputs combinationally in that cycle.
REQ-012 SHALL assert mem_chipselect only in a grant cycle; mem_write = granted p_write; mem_clken SHALL be tied high.
REQ-013 SHALL drive p_waitrequest = requesting AND NOT granted, combinationally; an ungranted request SHALL be held stable by the requester.
REQ-014 SHALL arbitrate using a registered last_grant pointer and a 4-bit run counter: with one requester, grant it; with both, grant m0 if last_grant=m1 or run counter < WEIGHT0, otherwise grant m1.
REQ-015 SHALL increment the run counter on each m0 grant while m1 is requesting, clear it on any m1 grant, and hold it when m0 is granted alone.
REQ-016 SHALL complete a write in its grant cycle, with no readdatavalid pulse.
REQ-017 SHALL register the read owner at a read grant and, exactly one cycle later, pulse that port's p_readdatavalid for one cycle with p_readdata = mem_readdata.
REQ-018 SHALL give read latency of exactly 1 cycle after grant, with back-to-back reads from either port sustaining one read per cycle.
REQ-019 SHALL drive p_readdata of a port from mem_readdata at all times; only readdatavalid qualifies it.
REQ-020 SHALL never pulse both readdatavalid outputs in the same cycle.
REQ-021 SHALL hold all pointers and counters when no port requests.

Reset
REQ-022 SHALL, while reset is high, grant nothing: mem_chipselect=0, mem_write=0, and p_waitrequest=1 for any requesting port.
REQ-023 SHALL set last_grant=m1 (so m0 wins first contention), run counter=0, read owner cleared, both p_readdatavalid=0 at reset.
REQ-024 SHALL drop a read granted in the cycle before reset assertion: no readdatavalid after reset.

Structure
REQ-025 SHALL place the port-select encoding (PORT_M0, PORT_M1) and the WEIGHT0 range limits in a shared package onchip_mem_pkg.
REQ-026 SHALL implement the grant decision in a sub-module rr_weighted_arbiter (inputs req[1:0], outputs gnt[1:0], owns last_grant and run counter); the read-return pipeline stays in the top level.

Verification
REQ-027 SHALL verify m0 read addr 0x005 alone -> grant cycle 0, m0_readdatavalid=1 in cycle 1 with data at word 5, m0_waitrequest=0.
REQ-028 SHALL verify m0 and m1 reading continuously, WEIGHT0=1 -> grants alternate m0,m1,m0,m1; each readdatavalid 1 cycle after its grant.
REQ-029 SHALL verify WEIGHT0=3, both continuous -> grant pattern m0,m0,m0,m1 repeating; m1_waitrequest high 3 cycles per period.
REQ-030 SHALL verify m1 write 0xDEADBEEF to 0x3FF, debugaccess=1, byteenable=0xF, concurrent with m0 read 0x3FF -> m0 wins first, reads old value; subsequent m0 read returns 0xDEADBEEF.
REQ-031 SHALL verify reset asserted the cycle after an m1 read grant -> no m1_readdatavalid; after release, first contention grants m0.
REQ-032 SHALL verify byteenable=0x3 write of 0x12345678 to 0x010 over 0xFFFFFFFF -> readback 0xFFFF5678.
